div_seq_ctrl: RTL and testbench
===============================

# div_seq_ctrl

Multi-cycle sequencing controller for integer division in the EX stage. It accepts one DIV/DIVU request at a time and runs a 32-step restoring division on registered operands. It reports busy to the hazard unit so the pipeline stalls, and delivers quotient/remainder with a one-cycle done pulse for the HI/LO write. It is the sequential replacement for the single-cycle divider. Its results match that divider bit-for-bit, including the divide-by-zero convention.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a  in  32  dividend; sampled with start.
- b  in  32  divisor; sampled with start.
- flush  in  1  synchronous cancel (exception/branch flush).
- q  out  32  quotient register.
- r  out  32  remainder register.
- busy  out  1  high while state is CALC or FIXUP; drives the pipeline stall.
- done  out  1  one-cycle pulse; q/r valid and newly updated.

## Operation
- States:
  - IDLE: waits for start.
  - CALC: iterates; step counter cnt runs 0..31.
  - FIXUP: applies signs and writes outputs.
- IDLE, start=1, b!=0:
  - Latch |a| and |b| when is_signed, otherwise raw a and b.
  - Latch neg_q = is_signed & (a[31]^b[31]) and neg_r = is_signed & a[31].
  - Clear the 33-bit partial remainder and cnt; go to CALC.
- IDLE, start=1, b==0: latch a zero-divisor flag and go directly to FIXUP. The result is q=0, r=0 regardless of is_signed.
- CALC, each edge: one restoring step.
  - Shift {rem, dvd} left by 1.
  - Trial subtract the divisor; if the result is non-negative, keep it and set the quotient LSB to 1, else restore and set it to 0.
  - cnt++; when cnt==31, go to FIXUP.
- FIXUP, next edge:
  - q = neg_q ? -quot : quot; r = neg_r ? -rem : rem.
  - Zeros if the zero-divisor flag is set.
  - done=1 for one cycle; go to IDLE.
- Sign convention: quotient truncates toward zero; remainder takes the dividend's sign.
- Magnitudes are 32-bit unsigned, so |0x80000000| = 0x80000000.
- Signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0, with no trap.
- start while busy is ignored; there is no queueing. The issuing stage is already stalled by busy.
- flush in CALC or FIXUP: return to IDLE next edge, no done, q/r unchanged.
- flush in IDLE has no effect. flush and start together in IDLE: flush wins, and the request is dropped.
- q/r hold the last completed result until the next done.

## Timing
- Reset values: state=IDLE, cnt=0, q=0, r=0, busy=0, done=0, all internal registers 0.
- rst takes priority over flush and start at any point, including mid-CALC.
- Normal latency, with start high in cycle 0:
  - busy is high in cycles 1..33.
  - done is high in cycle 34 with busy=0; q/r are valid from cycle 34 on.
- Zero divisor: busy high in cycle 1 only; done in cycle 2.
- A new start may be presented in the done cycle, because the state is already IDLE. It is accepted back-to-back.
- busy and done are registered outputs, with no combinational path from inputs.

## Structure
- Shared package/header div_pkg holds:
  - the state encoding (IDLE=2'd0, CALC=2'd1, FIXUP=2'd2);
  - DIV_STEPS=32;
  - the WIDTH constant.
- Sub-module div_step: purely combinational.
  - Inputs: 33-bit rem, 32-bit dvd, 32-bit divisor.
  - Outputs: next rem, next dvd with quotient bit inserted.
  - Instantiated once inside div_seq_ctrl.
- The FSM, counter, sign latches and output registers live in div_seq_ctrl.

## Test plan
- Unsigned 100/7 (is_signed=0, start in cycle 0) -> busy cycles 1..33; done cycle 34 with q=14, r=2.
- Signed -7/2 (a=0xFFFFFFF9, b=2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1.
- Overflow and unsigned extremes:
  - Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
  - Same operands unsigned -> q=0, r=0x80000000.
- b=0, both modes, a=0x12345678 -> done in cycle 2, q=0, r=0; busy high only in cycle 1.
- Flush and ignored start:
  - flush in cycle 10 -> busy=0 from cycle 11, no done, q/r keep the previous result.
  - Then start 9/3 -> q=3, r=0, 34 cycles later.
  - start pulsed mid-CALC -> ignored, with no effect on the result.
- Reset and back-to-back:
  - rst in cycle 20 of a division -> all outputs 0 next cycle, state IDLE.
  - A second start in the done cycle -> accepted; its done arrives 34 cycles later.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, step count
// and operand width, plus the magnitude helper used when latching operands.
package div_pkg;

    localparam int WIDTH     = 32;
    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } div_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, dvd} left, trial-subtract the
// divisor, keep or restore, and insert the quotient bit into dvd.
module div_step
    import div_pkg::*;
(
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic [WIDTH-1:0] next_dvd
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        diff    = shifted - {2'b00, divisor};
        // Sign bit of the wide difference clear means the trial subtract fits.
        if (!diff[WIDTH+1]) begin
            next_rem = diff[WIDTH:0];
            next_dvd = {dvd[WIDTH-2:0], 1'b1};
        end else begin
            next_rem = shifted[WIDTH:0];
            next_dvd = {dvd[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: 32 restoring steps on
// latched magnitudes, sign fixup, registered busy/done for the hazard unit.
module div_seq_ctrl
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    div_state_e       state, state_next;
    logic [4:0]       cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             neg_q, neg_r, zero_div;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_dvd;
    logic             accept;

    assign accept = start && !flush;

    div_step u_step (
        .rem      (rem),
        .dvd      (dvd),
        .divisor  (dvs),
        .next_rem (step_rem),
        .next_dvd (step_dvd)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_next; no latch.
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (b == '0) ? FIXUP : CALC;
            CALC: begin
                if (flush)                             state_next = IDLE;
                else if (cnt == 5'(DIV_STEPS - 1))     state_next = FIXUP;
            end
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
            q        <= '0;
            r        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_next == CALC) || (state_next == FIXUP);
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd      <= is_signed ? abs_val(a) : a;
                        dvs      <= is_signed ? abs_val(b) : b;
                        neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= is_signed & a[WIDTH-1];
                        zero_div <= (b == '0);
                        rem      <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        rem <= step_rem;
                        dvd <= step_dvd;
                        cnt <= cnt + 5'd1;
                    end
                end
                FIXUP: begin
                    // A flush here drops the result; q/r keep the previous one.
                    if (!flush) begin
                        q    <= zero_div ? '0 : (neg_q ? (~dvd + 1'b1) : dvd);
                        r    <= zero_div ? '0 : (neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0]);
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: table of division vectors with hand-computed
// results and latencies, plus flush, ignored-start, back-to-back and reset sequences.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;

    int tests  = 0;
    int failed = 0;

    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        int          exp_done;
    } vec_t;

    vec_t vecs[9];

    div_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .q         (q),
        .r         (r),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_start(input logic s, input logic [31:0] av, input logic [31:0] bv);
        is_signed = s;
        a         = av;
        b         = bv;
        start     = 1'b1;
    endtask

    // Called just after a negedge (cycle 0). flush_cyc/poke_cyc of 0 disable
    // those events; chain stops at the done cycle so the caller can issue again.
    task automatic run_div(input string name, input logic s, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] exp_q,
                           input logic [31:0] exp_r, input int exp_done,
                           input int flush_cyc, input int poke_cyc, input bit chain);
        int  done_cyc  = 0;
        int  done_cnt  = 0;
        bit  busy_ok   = 1'b1;
        int  busy_last = (flush_cyc > 0) ? flush_cyc : exp_done - 1;
        apply_start(s, av, bv);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            if (busy !== (cyc <= busy_last)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (exp_done > 0 && cyc == exp_done) begin
                check({name, " q"}, q, exp_q);
                check({name, " r"}, r, exp_r);
            end
            if (cyc == flush_cyc) flush = 1'b1;
            if (cyc == poke_cyc)  apply_start(1'b0, 32'd5, 32'd1);
            if (chain && cyc == exp_done) break;
        end
        check({name, " busy window"}, {31'd0, busy_ok}, 32'd1);
        check({name, " done cycle"}, done_cyc, exp_done);
        check({name, " done pulses"}, done_cnt, (exp_done > 0) ? 1 : 0);
        if (exp_done > 0) begin
            last_q = exp_q;
            last_r = exp_r;
        end else begin
            check({name, " q held"}, q, last_q);
            check({name, " r held"}, r, last_r);
        end
    endtask

    initial begin
        vecs[0] = '{"u 100/7",        1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        34};
        vecs[1] = '{"s -7/2",         1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 34};
        vecs[2] = '{"s 7/-2",         1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        34};
        vecs[3] = '{"s min/-1",       1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        34};
        vecs[4] = '{"u 8000_0000/ffff_ffff", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,  32'h80000000, 34};
        vecs[5] = '{"s -100/-7",      1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 34};
        vecs[6] = '{"u max/1",        1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        34};
        vecs[7] = '{"s div0",         1'b1, 32'h12345678, 32'd0,        32'd0,        32'd0,        2};
        vecs[8] = '{"u div0",         1'b0, 32'h12345678, 32'd0,        32'd0,        32'd0,        2};

        rst = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset q",    q, 32'd0);
        check("reset r",    r, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ends on a nonzero result so the flush case can see q/r hold.
        for (int i = 0; i < 9; i++)
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].av, vecs[i].bv,
                    vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_done, 0, 0, 1'b0);
        run_div("u 100/7 again", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 0, 0, 1'b0);

        run_div("flush@10",    1'b0, 32'd1000, 32'd10, 32'd0, 32'd0, 0, 10, 0, 1'b0);
        run_div("u 9/3",       1'b0, 32'd9,    32'd3,  32'd3, 32'd0, 34, 0, 0, 1'b0);
        run_div("poke mid",    1'b0, 32'd100,  32'd7,  32'd14, 32'd2, 34, 0, 5, 1'b0);

        run_div("b2b first",   1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, 0, 0, 1'b1);
        run_div("b2b second",  1'b0, 32'd9,    32'd3,  32'd3, 32'd0, 34, 0, 0, 1'b0);

        // Reset in cycle 20 of a division clears everything on the next cycle.
        apply_start(1'b0, 32'd1000, 32'd10);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-rst busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst q",    q, 32'd0);
        check("mid rst r",    r, 32'd0);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        last_q = 32'd0;
        last_r = 32'd0;
        @(negedge clk);
        run_div("post rst 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
